// File: rtl/xfiles_seq_pkg.sv
// Shared types and RoCC funct encodings for the X-FILES request sequencer.
package xfiles_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASID,
        S_NEWREQ,
        S_WAIT_TID,
        S_WRITE,
        S_WAIT_DONE,
        S_READ,
        S_FINISH,
        S_ERR
    } state_e;

    localparam logic [6:0] FUNCT_ASID       = 7'd0;
    localparam logic [6:0] FUNCT_WRITE_REQ  = 7'd3;
    localparam logic [6:0] FUNCT_WRITE_DATA = 7'd1;
    localparam logic [6:0] FUNCT_READ       = 7'd0;
    localparam int         FUNCT_LAST_BIT   = 2;

    // Write-data funct, with the "last word" flag folded in.
    function automatic logic [6:0] write_funct(input logic last);
        write_funct = FUNCT_WRITE_DATA | (7'(last) << FUNCT_LAST_BIT);
    endfunction

endpackage

// File: rtl/xfiles_req_sequencer_if.sv
// RoCC command/response channel between the sequencer (master) and accelerator.
interface xfiles_req_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_funct;
    logic [63:0] cmd_rs1;
    logic [63:0] cmd_rs2;
    logic        cmd_s;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;

    modport master (
        output cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_s, resp_ready,
        input  cmd_ready, resp_valid, resp_data
    );

    modport slave (
        input  cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_s, resp_ready,
        output cmd_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sram_r1_w1_rw0.sv
// Simple dual-port buffer: one write port, one registered read port.
module sram_r1_w1_rw0 #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read: data for raddr appears one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/xfiles_req_sequencer.sv
// Drives one X-FILES transaction: ASID, new write request, data words,
// wait for completion, then read results back into the shared buffer.
module xfiles_req_sequencer
    import xfiles_seq_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 32,
    parameter  int TO_W   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            asid,
    input  logic [31:0]            nnid,
    input  logic [CW-1:0]          num_in,
    input  logic [CW-1:0]          num_out,
    input  logic                   buf_we,
    input  logic [AW-1:0]          buf_addr,
    input  logic [DATA_W-1:0]      buf_wdata,
    output logic [DATA_W-1:0]      buf_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            tid,
    input  logic                   xf_done,
    xfiles_req_sequencer_if.master rocc
);
    // Counter value whose increment would hit all-ones: that cycle times out.
    localparam logic [TO_W-1:0] TO_HIT = {{(TO_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, rsp_q, rsp_d, nin_q, nin_d, nout_q, nout_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [15:0]       tid_q, tid_d, asid_q, asid_d;
    logic [31:0]       nnid_q, nnid_d;
    logic              done_q, done_d, err_q, err_d, rdy_q;
    logic              cmd_hs, resp_hs, rd_we, last_wr;
    logic [DATA_W-1:0] mem_rdata;

    assign busy    = !(state_q inside {S_IDLE, S_FINISH, S_ERR});
    assign done    = done_q;
    assign err     = err_q;
    assign tid     = tid_q;
    assign last_wr = (cnt_q == nin_q - 1'b1);
    assign cmd_hs  = rocc.cmd_valid && rocc.cmd_ready;
    assign resp_hs = rocc.resp_valid && rdy_q;
    // Responses are always sunk; unwanted ones are simply dropped.
    assign rocc.resp_ready = rdy_q;

    // The host owns the buffer while idle. While busy the read port prefetches
    // the next word to send, so it is valid in the cycle it is presented.
    sram_r1_w1_rw0 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (busy ? rd_we : buf_we),
        .waddr (busy ? rsp_q[AW-1:0] : buf_addr),
        .wdata (busy ? rocc.resp_data[DATA_W-1:0] : buf_wdata),
        .raddr (busy ? cnt_d[AW-1:0] : buf_addr),
        .rdata (mem_rdata)
    );
    assign buf_rdata = mem_rdata;

    // Command channel contents, a pure function of registered state.
    always_comb begin
        rocc.cmd_valid = 1'b0;
        rocc.cmd_funct = '0;
        rocc.cmd_rs1   = '0;
        rocc.cmd_rs2   = '0;
        rocc.cmd_s     = 1'b0;
        case (state_q)
            S_ASID: begin
                rocc.cmd_valid = 1'b1;
                rocc.cmd_s     = 1'b1;
                rocc.cmd_funct = FUNCT_ASID;
                rocc.cmd_rs1   = 64'(asid_q);
            end
            S_NEWREQ: begin
                rocc.cmd_valid = 1'b1;
                rocc.cmd_funct = FUNCT_WRITE_REQ;
                rocc.cmd_rs2   = 64'(nnid_q);
            end
            S_WRITE: begin
                rocc.cmd_valid = 1'b1;
                rocc.cmd_funct = write_funct(last_wr);
                rocc.cmd_rs1   = 64'(tid_q);
                rocc.cmd_rs2   = 64'(mem_rdata);
            end
            S_READ: begin
                rocc.cmd_valid = (cnt_q < nout_q);
                rocc.cmd_funct = FUNCT_READ;
                rocc.cmd_rs1   = 64'(tid_q);
            end
            default: ;
        endcase
    end

    // Next-state, counters, result capture and timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        nin_d   = nin_q;
        nout_d  = nout_q;
        to_d    = '0;
        tid_d   = tid_q;
        asid_d  = asid_q;
        nnid_d  = nnid_q;
        done_d  = done_q;
        err_d   = err_q;
        rd_we   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ASID;
                asid_d  = asid;
                nnid_d  = nnid;
                nin_d   = num_in;
                nout_d  = num_out;
                cnt_d   = '0;
                rsp_d   = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_ASID:     if (cmd_hs) state_d = S_NEWREQ;
            S_NEWREQ:   if (cmd_hs) state_d = S_WAIT_TID;
            S_WAIT_TID: if (resp_hs) begin
                tid_d   = rocc.resp_data[15:0];
                state_d = S_WRITE;
            end
            S_WRITE: if (cmd_hs) begin
                if (last_wr) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: if (xf_done) state_d = S_READ;
            S_READ: begin
                if (cmd_hs) cnt_d = cnt_q + 1'b1;
                if (resp_hs && rsp_q != nout_q) begin
                    rd_we = 1'b1;
                    rsp_d = rsp_q + 1'b1;
                end
                if (cnt_d == nout_q && rsp_d == nout_q) begin
                    state_d = S_FINISH;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Any busy state with no progress this cycle counts towards timeout.
        if (busy && state_d == state_q && !cmd_hs && !resp_hs) begin
            if (to_q == TO_HIT) begin
                state_d = S_ERR;
                err_d   = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
            nin_q   <= '0;
            nout_q  <= '0;
            to_q    <= '0;
            tid_q   <= '0;
            asid_q  <= '0;
            nnid_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
            nin_q   <= nin_d;
            nout_q  <= nout_d;
            to_q    <= to_d;
            tid_q   <= tid_d;
            asid_q  <= asid_d;
            nnid_q  <= nnid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule

// File: doc/xfiles_req_sequencer.md
XFILES_REQ_SEQUENCER -- requirements
Module: xfiles_req_sequencer
Interface
REQ-001 DATA_W, 32, width of each input/output word; legal range 1..64.
REQ-002 DEPTH, 32, number of shared buffer entries; AW = clog2(DEPTH), CW = clog2(DEPTH+1).
REQ-003 TO_W, 16, width of the timeout counter.
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that launches a transaction; sampled only in IDLE.
REQ-007 asid  in  16  ASID issued by the supervisor command.
REQ-008 nnid  in  32  network ID carried in the new-write-request command.
REQ-009 num_in  in  CW  count of input words to send; legal range 1..DEPTH.
REQ-010 num_out  in  CW  count of output words to read; legal range 1..DEPTH.
REQ-011 buf_we  in  1  host write strobe into the buffer; honoured only when busy=0.
REQ-012 buf_addr  in  AW  host buffer address used for both write and read.
REQ-013 buf_wdata  in  DATA_W  host write data.
REQ-014 buf_rdata  out  DATA_W  registered read data for buf_addr, valid 1 cycle after the address.
REQ-015 busy  out  1  high from start acceptance until FINISH or ERR is reached.
REQ-016 done  out  1  sticky success flag; cleared by the next accepted start.
REQ-017 err  out  1  sticky timeout flag; cleared by the next accepted start.
REQ-018 tid  out  16  TID captured from the response to the new-write request.
REQ-019 cmd_valid  out  1  RoCC command valid.
REQ-020 cmd_ready  in  1  RoCC command ready.
REQ-021 cmd_funct  out  7  RoCC funct field.
REQ-022 cmd_rs1  out  64  RoCC rs1 operand.
REQ-023 cmd_rs2  out  64  RoCC rs2 operand.
REQ-024 cmd_s  out  1  supervisor flag for the command.
REQ-025 resp_valid  in  1  RoCC response valid.
REQ-026 resp_ready  out  1  RoCC response ready.
REQ-027 resp_data  in  64  RoCC response data.
REQ-028 xf_done  in  1  level signal from the accelerator: transaction table entry done.
Function
REQ-029 The FSM SHALL step through IDLE -> ASID -> NEWREQ -> WAIT_TID -> WRITE -> WAIT_DONE -> READ -> FINISH -> IDLE; any waiting state SHALL go to ERR on timeout, and ERR SHALL go to IDLE on the next cycle.
REQ-030 A command SHALL transfer only on a cycle with cmd_valid and cmd_ready both high, and all cmd_* outputs SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-031 ASID SHALL drive cmd_s=1, cmd_funct=0 and cmd_rs1={48'b0,asid}; every other state SHALL drive cmd_s=0.
REQ-032 NEWREQ SHALL drive cmd_funct=3, cmd_rs1=0 and cmd_rs2={32'b0,nnid}.
REQ-033 WAIT_TID SHALL hold resp_ready=1 and, on the resp_valid handshake, capture tid=resp_data[15:0].
REQ-034 WRITE SHALL issue num_in commands with rs1=tid and rs2 equal to the zero-extended buffer entries 0..num_in-1 in order; cmd_funct SHALL be 1, except 5 on the last word.
REQ-035 WAIT_DONE SHALL advance on the first cycle xf_done=1.
REQ-036 READ SHALL issue num_out commands with cmd_funct=0 and rs1=tid, and SHALL hold resp_ready=1 throughout.
REQ-037 Each response accepted in READ SHALL write resp_data[DATA_W-1:0] to buffer entry k (k=0,1,...), in place over the inputs.
REQ-038 READ SHALL exit only when both the issue count and the response count equal num_out; an issue and a response in the same cycle SHALL update both counters.
REQ-039 Responses arriving outside WAIT_TID and READ SHALL be accepted (resp_ready=1) and discarded.
REQ-040 The timeout counter SHALL reset on every state change and every handshake; reaching 2^TO_W-1 SHALL set err and leave the buffer contents unchanged.
REQ-041 start SHALL be ignored while busy=1, and buf_we SHALL be ignored while busy=1.
REQ-042 done SHALL be set on entry to FINISH; done and err SHALL never both be high.
Reset
REQ-043 Asserting rst low at any time, including mid-transaction, SHALL force IDLE and zero all outputs, counters and tid; buffer contents are undefined after reset.
Structure
REQ-044 Package xfiles_seq_pkg SHALL hold the FSM state enum and the FUNCT_WRITE_REQ=3, FUNCT_WRITE_DATA=1, FUNCT_LAST_BIT=2 and FUNCT_READ=0 constants; the buffer SHALL be the existing sram_r1_w1_rw0 sub-module.
Verification
REQ-045 Load 30 words (1024/0 pattern), start, nnid=0, model returns TID 0x2A -> 30 writes, the last with funct 5, then 30 reads with rs1=0x2A, done=1, buffer holds the responses.
REQ-046 cmd_ready held low 5 cycles during WRITE -> cmd_rs2 stays stable and no word is skipped or duplicated.
REQ-047 Responses delayed 3 cycles and overlapping new read issues -> exactly num_out entries are written and FINISH is reached.
REQ-048 xf_done never asserted with TO_W=4 -> err=1 after 15 idle cycles, done=0, FSM returns to IDLE; a start pulse with num_in=1 then succeeds.
